cpm_bank_sched: RTL
===================

// Module: cpm_bank_sched
// PURPOSE
//  Schedules REQ_DW requesters onto BANK_DW shared banks (e.g. CPM SRAM banks).
//  Each requester holds one pending bank access (bank idx + data). A per-bank
//  round-robin arbiter picks one pending requester per free bank each cycle, and
//  a per-bank output register drives the bank with valid/ready.
//  Sits between PE-side requesters and the bank memories, in place of a bare
//  combinational multi-input arbiter.
// PARAMETERS
//  REQ_DW   4                 number of requesters
//  BANK_DW  4                 number of banks
//  IDX_AW   $clog2(BANK_DW)   bank index width (min 1)
//  REQ_AW   $clog2(REQ_DW)    requester id width (min 1)
//  DAT_DW   16                payload width
// PORTS
//  clk      in   1               clock, rising edge
//  rst_n    in   1               asynchronous reset, active low
//  FLUSH    in   1               sync clear of pending slots and output regs
//  REQ_VLD  in   REQ_DW          per-requester request valid
//  REQ_RDY  out  REQ_DW          per-requester ready; accept = VLD & RDY
//  REQ_IDX  in   REQ_DW*IDX_AW   target bank, requester r at [r*IDX_AW +: IDX_AW]
//  REQ_DAT  in   REQ_DW*DAT_DW   payload, requester r at [r*DAT_DW +: DAT_DW]
//  BNK_VLD  out  BANK_DW         bank access valid
//  BNK_RDY  in   BANK_DW         bank accepts; transfer = VLD & RDY
//  BNK_DAT  out  BANK_DW*DAT_DW  payload to bank b
//  BNK_SRC  out  BANK_DW*REQ_AW  requester id of the access to bank b
//  BUSY     out  1               any pending slot or output reg valid
//  ERR_IDX  out  1               sticky: request with REQ_IDX >= BANK_DW accepted
// BEHAVIOUR
//  Reset: pend_vld=0, obuf_vld=0, BNK_DAT=0, BNK_SRC=0, rr_ptr[b]=0, ERR_IDX=0;
//   so REQ_RDY=all ones, BNK_VLD=0, BUSY=0.
//  Pending slot r: pend_vld/idx/dat. win[r] = r granted this cycle.
//   REQ_RDY[r] = ~pend_vld[r] | win[r] (comb path BNK_RDY->REQ_RDY is allowed).
//   On accept: load slot; pend_vld stays 1. On win without accept: pend_vld<=0.
//  Bank b is free when bank_free[b] = ~obuf_vld[b] | BNK_RDY[b].
//  Arbitration, bank b: candidates = pend_vld[r] & pend_idx[r]==b. If bank_free[b],
//   grant the first candidate scanning r = rr_ptr[b], rr_ptr[b]+1, ... mod REQ_DW.
//   Winner w: obuf[b] <= {pend_dat[w], w}, obuf_vld[b] <= 1,
//   rr_ptr[b] <= (w+1) mod REQ_DW. No candidate: rr_ptr[b] held.
//  Bank b free with no winner: obuf_vld[b] <= 0; BNK_DAT/BNK_SRC hold last value.
//  BNK_VLD/BNK_DAT/BNK_SRC come straight from obuf, stable while VLD & ~RDY.
//  Each requester targets one bank, so at most one win per requester per cycle.
//  Latency: handshake in cycle N -> pending in N+1 -> BNK_VLD earliest in N+2.
//  Throughput: 1 access/bank/cycle; 1 accept/requester/cycle when uncontended.
//  Per-requester order preserved (single slot); no loss, no duplicate under
//   any BNK_RDY pattern.
//  REQ_IDX >= BANK_DW (BANK_DW not power of 2): accepted, not stored
//   (pend_vld stays 0), ERR_IDX <= 1 until reset.
//  FLUSH (priority over accept/grant): pend_vld<=0, obuf_vld<=0 next edge;
//   rr_ptr and ERR_IDX kept; REQ_RDY ignored while FLUSH=1 (no accept).
//  rst_n low mid-operation: all state cleared immediately, in-flight dropped.
// STRUCTURE
//  Shared package cpm_sched_pkg: REQ_AW/IDX_AW helpers, rotate-priority function.
//  Sub-module cpm_rr_pick (REQ_DW-bit candidate vector + rr_ptr -> one-hot grant
//   + encoded id), instantiated BANK_DW times via generate.
//  Top holds pending slots, output regs, rr pointers, ERR/BUSY logic.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> REQ_RDY=4'b1111, BNK_VLD=0, BUSY=0, ERR_IDX=0.
//  2 Contention: r0..r3 stream to bank 2, BNK_RDY=1 -> BNK_SRC[2] = 0,1,2,3,0,...
//    BNK_VLD[2]=1 every cycle, each requester one grant per 4 cycles.
//  3 Disjoint: r_i streams to bank i, BNK_RDY=4'hF -> BNK_VLD=4'hF from cycle 2,
//    REQ_RDY stays 4'hF, BNK_DAT[i] equals r_i data sequence, no gaps.
//  4 Backpressure: r1 streams D0..D9 to bank 1, BNK_RDY[1]=0 for 5 cycles ->
//    BNK_DAT[1]=D0 held, REQ_RDY[1]=0 after D1 accepted; release -> D0..D9 in order.
//  5 FLUSH with r0,r3 pending and BNK_VLD[0]=1 -> next cycle BNK_VLD=0,
//    BUSY=0, REQ_RDY=4'hF; next contention resumes from kept rr_ptr.
//  6 BANK_DW=3: r2 sends REQ_IDX=3 -> ERR_IDX=1 next cycle, no BNK_VLD, REQ_RDY[2]=1.

Source files
------------

// File: rtl/cpm_sched_pkg.sv
// Shared sizing helpers and round-robin scan ordering for the CPM bank scheduler.
package cpm_sched_pkg;

    function automatic int unsigned width_min1(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    // Requester visited at step k of a scan starting at ptr; both ptr and k are below n.
    function automatic int unsigned rr_index(input int unsigned ptr, input int unsigned k,
                                             input int unsigned n);
        int unsigned s;
        s = ptr + k;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/cpm_rr_pick.sv
// Round-robin picker: first set candidate at or after ptr_i, as one-hot grant and encoded id.
module cpm_rr_pick
    import cpm_sched_pkg::*;
#(
    parameter int unsigned REQ_DW = 4,
    parameter int unsigned REQ_AW = width_min1(REQ_DW)
) (
    input  logic [REQ_DW-1:0] cand_i,
    input  logic [REQ_AW-1:0] ptr_i,
    output logic              any_o,
    output logic [REQ_DW-1:0] gnt_o,
    output logic [REQ_AW-1:0] id_o
);

    logic [REQ_AW-1:0] pos;

    always_comb begin
        any_o = 1'b0;
        gnt_o = '0;
        id_o  = '0;
        pos   = '0;
        for (int unsigned k = 0; k < REQ_DW; k++) begin
            pos = REQ_AW'(rr_index(32'(ptr_i), k, REQ_DW));
            if (!any_o && cand_i[pos]) begin
                any_o      = 1'b1;
                gnt_o[pos] = 1'b1;
                id_o       = pos;
            end
        end
    end

endmodule

// File: rtl/cpm_bank_sched.sv
// Per-requester single-entry pending slots scheduled onto shared banks through per-bank
// round-robin pickers and registered bank-side valid/ready outputs.
module cpm_bank_sched
    import cpm_sched_pkg::*;
#(
    parameter int unsigned REQ_DW  = 4,
    parameter int unsigned BANK_DW = 4,
    parameter int unsigned IDX_AW  = width_min1(BANK_DW),
    parameter int unsigned REQ_AW  = width_min1(REQ_DW),
    parameter int unsigned DAT_DW  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      FLUSH,
    input  logic [REQ_DW-1:0]         REQ_VLD,
    output logic [REQ_DW-1:0]         REQ_RDY,
    input  logic [REQ_DW*IDX_AW-1:0]  REQ_IDX,
    input  logic [REQ_DW*DAT_DW-1:0]  REQ_DAT,
    output logic [BANK_DW-1:0]        BNK_VLD,
    input  logic [BANK_DW-1:0]        BNK_RDY,
    output logic [BANK_DW*DAT_DW-1:0] BNK_DAT,
    output logic [BANK_DW*REQ_AW-1:0] BNK_SRC,
    output logic                      BUSY,
    output logic                      ERR_IDX
);

    logic [REQ_DW-1:0][IDX_AW-1:0]  req_idx;
    logic [REQ_DW-1:0][DAT_DW-1:0]  req_dat;

    logic [REQ_DW-1:0]              pend_vld_q, pend_vld_d;
    logic [REQ_DW-1:0][IDX_AW-1:0]  pend_idx_q, pend_idx_d;
    logic [REQ_DW-1:0][DAT_DW-1:0]  pend_dat_q, pend_dat_d;
    logic [BANK_DW-1:0]             obuf_vld_q, obuf_vld_d;
    logic [BANK_DW-1:0][DAT_DW-1:0] obuf_dat_q, obuf_dat_d;
    logic [BANK_DW-1:0][REQ_AW-1:0] obuf_src_q, obuf_src_d;
    logic [BANK_DW-1:0][REQ_AW-1:0] rr_ptr_q, rr_ptr_d;
    logic                           err_q, err_d;

    logic [BANK_DW-1:0]             bank_free;
    logic [BANK_DW-1:0]             gnt_any;
    logic [BANK_DW-1:0][REQ_DW-1:0] cand;
    logic [BANK_DW-1:0][REQ_DW-1:0] gnt;
    logic [BANK_DW-1:0][REQ_AW-1:0] gnt_id;
    logic [REQ_DW-1:0]              win;
    logic [REQ_DW-1:0]              acc;

    assign req_idx = REQ_IDX;
    assign req_dat = REQ_DAT;

    // FLUSH masks every candidate so no grant, pointer move or slot release happens.
    always_comb begin
        bank_free = '0;
        cand      = '0;
        for (int unsigned b = 0; b < BANK_DW; b++) begin
            bank_free[b] = ~obuf_vld_q[b] | BNK_RDY[b];
            for (int unsigned r = 0; r < REQ_DW; r++) begin
                cand[b][r] = pend_vld_q[r] & (pend_idx_q[r] == IDX_AW'(b))
                           & bank_free[b] & ~FLUSH;
            end
        end
    end

    for (genvar b = 0; b < BANK_DW; b++) begin : g_pick
        cpm_rr_pick #(
            .REQ_DW (REQ_DW),
            .REQ_AW (REQ_AW)
        ) u_pick (
            .cand_i (cand[b]),
            .ptr_i  (rr_ptr_q[b]),
            .any_o  (gnt_any[b]),
            .gnt_o  (gnt[b]),
            .id_o   (gnt_id[b])
        );
    end

    always_comb begin
        win = '0;
        for (int unsigned b = 0; b < BANK_DW; b++) begin
            win = win | gnt[b];
        end
    end

    assign REQ_RDY = ~pend_vld_q | win;
    assign acc     = REQ_VLD & REQ_RDY & {REQ_DW{~FLUSH}};

    always_comb begin
        pend_vld_d = pend_vld_q & ~win;
        pend_idx_d = pend_idx_q;
        pend_dat_d = pend_dat_q;
        obuf_vld_d = obuf_vld_q;
        obuf_dat_d = obuf_dat_q;
        obuf_src_d = obuf_src_q;
        rr_ptr_d   = rr_ptr_q;
        err_d      = err_q;

        // Out-of-range bank indices are consumed but never stored.
        for (int unsigned r = 0; r < REQ_DW; r++) begin
            if (acc[r]) begin
                if (32'(req_idx[r]) >= BANK_DW) begin
                    err_d = 1'b1;
                end else begin
                    pend_vld_d[r] = 1'b1;
                    pend_idx_d[r] = req_idx[r];
                    pend_dat_d[r] = req_dat[r];
                end
            end
        end

        for (int unsigned b = 0; b < BANK_DW; b++) begin
            if (bank_free[b]) begin
                obuf_vld_d[b] = gnt_any[b];
                if (gnt_any[b]) begin
                    obuf_dat_d[b] = pend_dat_q[gnt_id[b]];
                    obuf_src_d[b] = gnt_id[b];
                    rr_ptr_d[b]   = REQ_AW'(rr_index(32'(gnt_id[b]), 32'd1, REQ_DW));
                end
            end
        end

        if (FLUSH) begin
            pend_vld_d = '0;
            obuf_vld_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= '0;
            pend_idx_q <= '0;
            pend_dat_q <= '0;
            obuf_vld_q <= '0;
            obuf_dat_q <= '0;
            obuf_src_q <= '0;
            rr_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
            pend_dat_q <= pend_dat_d;
            obuf_vld_q <= obuf_vld_d;
            obuf_dat_q <= obuf_dat_d;
            obuf_src_q <= obuf_src_d;
            rr_ptr_q   <= rr_ptr_d;
            err_q      <= err_d;
        end
    end

    assign BNK_VLD = obuf_vld_q;
    assign BNK_DAT = obuf_dat_q;
    assign BNK_SRC = obuf_src_q;
    assign BUSY    = (|pend_vld_q) | (|obuf_vld_q);
    assign ERR_IDX = err_q;

endmodule
